id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 47 ++++
 rtl/id_ex_hazard.sv | 23 ++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX pipeline register, the control unit and the ALU control unit.
// Also holds the ID/EX FSM state type and the per-cycle register update action.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        RegDstRd  = 2'd0,
        RegDstRt  = 2'd1,
        RegDstFd  = 2'd2,
        RegDstR31 = 2'd3
    } reg_dst_e;

    typedef enum logic [2:0] {
        WbAlu  = 3'd0,
        WbMem  = 3'd1,
        WbUimm = 3'd2,
        WbPc4  = 3'd3
    } wb_src_e;

    typedef enum logic [2:0] {
        ExOpAdd   = 3'd0,
        ExOpSub   = 3'd1,
        ExOpAnd   = 3'd2,
        ExOpOr    = 3'd3,
        ExOpSlt   = 3'd4,
        ExOpFunct = 3'd5,
        ExOpLui   = 3'd6,
        ExOpFpu   = 3'd7
    } ex_op_e;

    typedef enum logic {
        StRun = 1'b0,
        StDw2 = 1'b1
    } id_ex_state_e;

    typedef enum logic [1:0] {
        ActLoad   = 2'd0,
        ActBubble = 2'd1,
        ActHold   = 2'd2
    } id_ex_action_e;

    // First beat of a double-precision load or store sitting in EX.
    function automatic logic is_double_mem(logic dw, logic mem_write, logic [2:0] wb_src,
                                           logic beat);
        return dw && (mem_write || (wb_src == WbMem)) && !beat;
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard check between the load in EX and the instruction in ID.
// Integer r0 never creates a hazard; float and integer register files never alias.
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic       ex_reg_write,
    input  logic [2:0] ex_wb_src,
    input  logic       ex_float,
    input  logic [4:0] ex_rt,
    input  logic       id_float,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    logic reg_match;

    assign reg_match = (ex_rt == id_rs) || (ex_rt == id_rt);

    assign load_use = ex_reg_write && (ex_wb_src == WbMem) && (ex_float == id_float) &&
                      reg_match && (ex_float || (ex_rt != 5'd0));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling and a two-beat hold for double memory ops.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_jr,
    input  logic        id_byte,
    input  logic        id_jump,
    input  logic        id_mem_write,
    input  logic        id_reg_write,
    input  logic        id_float,
    input  logic        id_shift,
    input  logic        id_dw,
    input  logic [1:0]  id_reg_dst,
    input  logic [2:0]  id_wb_src,
    input  logic [2:0]  id_ex_op,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic        flush,
    output logic        ex_jr,
    output logic        ex_byte,
    output logic        ex_jump,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_float,
    output logic        ex_shift,
    output logic        ex_dw,
    output logic [1:0]  ex_reg_dst,
    output logic [2:0]  ex_wb_src,
    output logic [2:0]  ex_ex_op,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic        ex_beat,
    output logic        stall
);

    id_ex_state_e  state_q, state_d;
    id_ex_action_e action;
    logic          load_use;
    logic          double_op;

    id_ex_hazard u_hazard (
        .ex_reg_write (ex_reg_write),
        .ex_wb_src    (ex_wb_src),
        .ex_float     (ex_float),
        .ex_rt        (ex_rt),
        .id_float     (id_float),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .load_use     (load_use)
    );

    assign double_op = is_double_mem(ex_dw, ex_mem_write, ex_wb_src, ex_beat);

    // Leaving DW2 still bubbles if the held load feeds the waiting ID instruction.
    always_comb begin
        state_d = StRun;
        action  = ActLoad;
        if (flush) begin
            action = ActBubble;
        end else if ((state_q == StRun) && double_op) begin
            action  = ActHold;
            state_d = StDw2;
        end else if (load_use) begin
            action = ActBubble;
        end
    end

    assign stall = (state_q == StDw2) || load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            ex_jr        <= 1'b0;
            ex_byte      <= 1'b0;
            ex_jump      <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_float     <= 1'b0;
            ex_shift     <= 1'b0;
            ex_dw        <= 1'b0;
            ex_reg_dst   <= RegDstRd;
            ex_wb_src    <= WbAlu;
            ex_ex_op     <= ExOpAdd;
            ex_pc4       <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_shamt     <= '0;
            ex_beat      <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_beat <= (action == ActHold);
            // Data fields follow ID on a bubble too; only control is defined as zero.
            if (action != ActHold) begin
                ex_pc4     <= id_pc4;
                ex_rs_data <= id_rs_data;
                ex_rt_data <= id_rt_data;
                ex_imm     <= id_imm;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_rd      <= id_rd;
                ex_shamt   <= id_shamt;
            end
            if (action == ActLoad) begin
                ex_jr        <= id_jr;
                ex_byte      <= id_byte;
                ex_jump      <= id_jump;
                ex_mem_write <= id_mem_write;
                ex_reg_write <= id_reg_write;
                ex_float     <= id_float;
                ex_shift     <= id_shift;
                ex_dw        <= id_dw;
                ex_reg_dst   <= id_reg_dst;
                ex_wb_src    <= id_wb_src;
                ex_ex_op     <= id_ex_op;
            end else if (action == ActBubble) begin
                ex_jr        <= 1'b0;
                ex_byte      <= 1'b0;
                ex_jump      <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_float     <= 1'b0;
                ex_shift     <= 1'b0;
                ex_dw        <= 1'b0;
                ex_reg_dst   <= RegDstRd;
                ex_wb_src    <= WbAlu;
                ex_ex_op     <= ExOpAdd;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenario table plus randomized traffic against a reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        jr, bt, jump, mw, rw, fl, sh, dw;
        logic [1:0]  reg_dst;
        logic [2:0]  wb_src, ex_op;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
    } instr_t;

    typedef struct {
        bit          rst, flush;
        instr_t      id;
        bit          chk;
        bit          stall, beat, rw;
        bit          chk_pc;
        logic [31:0] pc;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst, flush;
    instr_t id;

    logic        ex_jr, ex_byte, ex_jump, ex_mem_write, ex_reg_write, ex_float, ex_shift, ex_dw;
    logic [1:0]  ex_reg_dst;
    logic [2:0]  ex_wb_src, ex_ex_op;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic        ex_beat, stall;
    instr_t      act;

    always #5 clk = ~clk;

    assign act = {ex_jr, ex_byte, ex_jump, ex_mem_write, ex_reg_write, ex_float, ex_shift, ex_dw,
                  ex_reg_dst, ex_wb_src, ex_ex_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                  ex_rs, ex_rt, ex_rd, ex_shamt};

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_jr        (id.jr),
        .id_byte      (id.bt),
        .id_jump      (id.jump),
        .id_mem_write (id.mw),
        .id_reg_write (id.rw),
        .id_float     (id.fl),
        .id_shift     (id.sh),
        .id_dw        (id.dw),
        .id_reg_dst   (id.reg_dst),
        .id_wb_src    (id.wb_src),
        .id_ex_op     (id.ex_op),
        .id_pc4       (id.pc4),
        .id_rs_data   (id.rs_data),
        .id_rt_data   (id.rt_data),
        .id_imm       (id.imm),
        .id_rs        (id.rs),
        .id_rt        (id.rt),
        .id_rd        (id.rd),
        .id_shamt     (id.shamt),
        .flush        (flush),
        .ex_jr        (ex_jr),
        .ex_byte      (ex_byte),
        .ex_jump      (ex_jump),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .ex_float     (ex_float),
        .ex_shift     (ex_shift),
        .ex_dw        (ex_dw),
        .ex_reg_dst   (ex_reg_dst),
        .ex_wb_src    (ex_wb_src),
        .ex_ex_op     (ex_ex_op),
        .ex_pc4       (ex_pc4),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_shamt     (ex_shamt),
        .ex_beat      (ex_beat),
        .stall        (stall)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what EX should hold, whether a second beat is pending, data validity.
    instr_t m_ex;
    bit     m_dw2, m_beat, m_bub, m_valid;

    function automatic logic [15:0] ctrl_of(instr_t x);
        return {x.jr, x.bt, x.jump, x.mw, x.rw, x.fl, x.sh, x.dw, x.reg_dst, x.wb_src, x.ex_op};
    endfunction

    function automatic logic [147:0] data_of(instr_t x);
        return {x.pc4, x.rs_data, x.rt_data, x.imm, x.rs, x.rt, x.rd, x.shamt};
    endfunction

    function automatic bit hazard(instr_t e, instr_t d);
        if (!e.rw || e.wb_src != 3'd1 || e.fl != d.fl) return 1'b0;
        if (!e.fl && e.rt == 5'd0) return 1'b0;
        return (e.rt == d.rs) || (e.rt == d.rt);
    endfunction

    function automatic instr_t mk_i(bit rw, bit wb_mem, bit fl, bit dw, bit mw,
                                    logic [4:0] rs, logic [4:0] rt, logic [31:0] pc);
        instr_t x = '0;
        x.rw      = rw;
        x.wb_src  = wb_mem ? 3'd1 : 3'd0;
        x.fl      = fl;
        x.dw      = dw;
        x.mw      = mw;
        x.rs      = rs;
        x.rt      = rt;
        x.rd      = rt + 5'd1;
        x.shamt   = rs;
        x.reg_dst = 2'd1;
        x.ex_op   = 3'd2;
        x.pc4     = pc;
        x.rs_data = pc * 3;
        x.rt_data = ~pc;
        x.imm     = pc << 4;
        return x;
    endfunction

    task automatic check(string name, logic [191:0] got, logic [191:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic apply(bit r, bit f, instr_t d);
        rst   = r;
        flush = f;
        id    = d;
        @(negedge clk);
        if (m_valid) begin
            check("stall", 192'(stall), 192'(m_dw2 || hazard(m_ex, d)));
            check("ctrl", 192'({ctrl_of(act), ex_beat}), 192'({ctrl_of(m_ex), m_beat}));
            if (!m_bub) check("data", 192'(data_of(act)), 192'(data_of(m_ex)));
        end
    endtask

    task automatic advance(bit r, bit f, instr_t d);
        if (r) begin
            m_ex = '0; m_dw2 = 0; m_beat = 0; m_bub = 0; m_valid = 1;
        end else if (m_valid) begin
            if (f || (m_dw2 && hazard(m_ex, d))) begin
                m_ex = '0; m_bub = 1; m_dw2 = 0; m_beat = 0;
            end else if (!m_dw2 && m_ex.dw && (m_ex.mw || m_ex.wb_src == 3'd1)) begin
                m_dw2 = 1; m_beat = 1;
            end else if (hazard(m_ex, d)) begin
                m_ex = '0; m_bub = 1; m_beat = 0;
            end else begin
                m_ex = d; m_bub = 0; m_dw2 = 0; m_beat = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add(bit r, bit f, instr_t d, bit chk, bit s, bit b, bit rw,
                       bit chk_pc, logic [31:0] pc);
        vec_t v;
        v.rst = r; v.flush = f; v.id = d; v.chk = chk;
        v.stall = s; v.beat = b; v.rw = rw; v.chk_pc = chk_pc; v.pc = pc;
        vecs.push_back(v);
    endtask

    initial begin
        instr_t nop, lw5, add5, lw0, use0, ldc1, nxt, flw5, int5, r;
        bit rr, rf;
        nop  = '0;
        lw5  = mk_i(1, 1, 0, 0, 0, 5'd1, 5'd5,  32'h104);
        add5 = mk_i(1, 0, 0, 0, 0, 5'd5, 5'd6,  32'h108);
        lw0  = mk_i(1, 1, 0, 0, 0, 5'd1, 5'd0,  32'h200);
        use0 = mk_i(1, 0, 0, 0, 0, 5'd0, 5'd2,  32'h204);
        ldc1 = mk_i(1, 1, 1, 1, 0, 5'd2, 5'd4,  32'h300);
        nxt  = mk_i(1, 0, 0, 0, 0, 5'd9, 5'd10, 32'h304);
        flw5 = mk_i(1, 1, 1, 0, 0, 5'd1, 5'd5,  32'h400);
        int5 = mk_i(0, 0, 0, 0, 0, 5'd3, 5'd5,  32'h404);
        m_valid = 0; m_ex = '0; m_dw2 = 0; m_beat = 0; m_bub = 0;

        // rst flush id     chk stall beat rw chkpc pc   (EX as seen this cycle)
        add(1, 0, nop,  0, 0, 0, 0, 0, 32'h0);
        add(0, 0, lw5,  1, 0, 0, 0, 1, 32'h0);    // reset state
        add(0, 0, add5, 1, 1, 0, 1, 1, 32'h104);  // lw r5 vs rs=5
        add(0, 0, add5, 1, 0, 0, 0, 0, 32'h0);    // bubble
        add(0, 0, lw0,  1, 0, 0, 1, 1, 32'h108);  // add enters EX
        add(0, 0, use0, 1, 0, 0, 1, 1, 32'h200);  // lw r0, no stall
        add(0, 0, ldc1, 1, 0, 0, 1, 1, 32'h204);
        add(0, 0, nxt,  1, 0, 0, 1, 1, 32'h300);  // ldc1 beat 0
        add(0, 0, nxt,  1, 1, 1, 1, 1, 32'h300);  // ldc1 beat 1, held
        add(0, 0, nop,  1, 0, 0, 1, 1, 32'h304);  // next loaded
        add(0, 0, lw5,  1, 0, 0, 0, 1, 32'h0);
        add(0, 1, add5, 1, 1, 0, 1, 1, 32'h104);  // flush with hazard
        add(0, 0, add5, 1, 0, 0, 0, 0, 32'h0);    // bubble from flush
        add(0, 0, ldc1, 1, 0, 0, 1, 1, 32'h108);
        add(0, 0, nop,  1, 0, 0, 1, 1, 32'h300);
        add(1, 0, nop,  1, 1, 1, 1, 1, 32'h300);  // reset during DW2
        add(0, 0, flw5, 1, 0, 0, 0, 1, 32'h0);    // cleared by reset
        add(0, 0, int5, 1, 0, 0, 1, 1, 32'h400);  // float load vs int rt=5
        add(0, 0, nop,  1, 0, 0, 0, 1, 32'h404);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].flush, vecs[i].id);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_stall", i), 192'(stall), 192'(vecs[i].stall));
                check($sformatf("vec%0d_beat", i), 192'(ex_beat), 192'(vecs[i].beat));
                check($sformatf("vec%0d_rw", i), 192'(ex_reg_write), 192'(vecs[i].rw));
                if (vecs[i].chk_pc)
                    check($sformatf("vec%0d_pc", i), 192'(ex_pc4), 192'(vecs[i].pc));
            end
            advance(vecs[i].rst, vecs[i].flush, vecs[i].id);
        end

        for (int n = 0; n < 3000; n++) begin
            r         = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            r.rs      = 5'($urandom_range(0, 7));
            r.rt      = 5'($urandom_range(0, 7));
            r.wb_src  = 3'($urandom_range(0, 3));
            r.dw      = ($urandom_range(0, 3) == 0);
            rr        = ($urandom_range(0, 63) == 0);
            rf        = ($urandom_range(0, 7) == 0);
            apply(rr, rf, r);
            advance(rr, rf, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
